// File: rtl/digit_loader.sv
// Keypad digit entry with debounce, a three-digit shift buffer and a
// three-cycle load sequence into a downstream timer.
module digit_loader #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       clr,
  input  logic [9:0] keypad,
  input  logic       enter,
  input  logic       cancel,
  output logic [3:0] digit,
  output logic       loadn,
  output logic       busy,
  output logic [1:0] count,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  localparam int unsigned NKEY = 10;
  localparam int unsigned DW   = 4;
  localparam int unsigned CW   = 4;

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, DONE} state_t;

  state_t          state, state_d;
  logic [NKEY-1:0] key_r;
  logic            enter_r, enter_p, cancel_r, cancel_p;
  logic [CW-1:0]   stab_cnt, stab_cnt_d;
  logic [DW-1:0]   last_code;
  logic            armed;

  logic            key_valid_c, accept_c, enter_edge_c, cancel_edge_c;
  logic [DW-1:0]   key_code_c;
  logic [DW-1:0]   d2_d, d1_d, d0_d, digit_d;
  logic [1:0]      count_d;
  logic            loadn_d, busy_d;

  assign enter_edge_c  = enter_r & ~enter_p;
  assign cancel_edge_c = cancel_r & ~cancel_p;

  // Decode the sampled key lines and advance the stability count.
  always_comb begin
    key_valid_c = $onehot(key_r);
    key_code_c  = '0;
    for (int k = 0; k < NKEY; k++) begin
      if (key_r[k]) key_code_c = DW'(k);
    end
    stab_cnt_d = '0;
    if (key_valid_c) begin
      if (stab_cnt != '0 && key_code_c == last_code)
        stab_cnt_d = (stab_cnt >= CW'(DEBOUNCE)) ? stab_cnt : CW'(stab_cnt + CW'(1));
      else
        stab_cnt_d = CW'(1);
    end
    accept_c = armed & key_valid_c & (stab_cnt_d == CW'(DEBOUNCE));
  end

  // Input sampling and debounce state.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      key_r     <= '0;
      enter_r   <= 1'b0;
      enter_p   <= 1'b0;
      cancel_r  <= 1'b0;
      cancel_p  <= 1'b0;
      stab_cnt  <= '0;
      last_code <= '0;
      armed     <= 1'b1;
    end else begin
      key_r     <= keypad;
      enter_r   <= enter;
      enter_p   <= enter_r;
      cancel_r  <= cancel;
      cancel_p  <= cancel_r;
      stab_cnt  <= stab_cnt_d;
      last_code <= key_code_c;
      if (key_r == '0)
        armed <= 1'b1;
      else if (accept_c)
        armed <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, buffer update, and next values of the registered outputs.
  always_comb begin
    state_d = state;
    d2_d    = d2;
    d1_d    = d1;
    d0_d    = d0;
    count_d = count;
    loadn_d = 1'b1;
    digit_d = '0;
    busy_d  = 1'b0;
    case (state)
      IDLE: begin
        if (cancel_edge_c) begin
          d2_d    = '0;
          d1_d    = '0;
          d0_d    = '0;
          count_d = '0;
        end else if (enter_edge_c) begin
          if (count != '0) state_d = LOAD0;
        end else if (accept_c) begin
          d2_d    = d1;
          d1_d    = d0;
          d0_d    = key_code_c;
          count_d = (count == 2'd3) ? 2'd3 : 2'(count + 2'd1);
        end
      end
      LOAD0: state_d = LOAD1;
      LOAD1: state_d = LOAD2;
      LOAD2: begin
        state_d = DONE;
        d2_d    = '0;
        d1_d    = '0;
        d0_d    = '0;
        count_d = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // Unfilled leading positions hold 0, so short buffers still send 3 digits.
    case (state_d)
      LOAD0: begin loadn_d = 1'b0; digit_d = d2; end
      LOAD1: begin loadn_d = 1'b0; digit_d = d1; end
      LOAD2: begin loadn_d = 1'b0; digit_d = d0; end
      default: begin loadn_d = 1'b1; digit_d = '0; end
    endcase
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      d2    <= '0;
      d1    <= '0;
      d0    <= '0;
      count <= '0;
      loadn <= 1'b1;
      digit <= '0;
      busy  <= 1'b0;
    end else begin
      d2    <= d2_d;
      d1    <= d1_d;
      d0    <= d0_d;
      count <= count_d;
      loadn <= loadn_d;
      digit <= digit_d;
      busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_digit_loader.sv
// Directed bench for digit_loader: buffer checks plus a scoreboard of the
// digits expected on each loadn-low cycle.
module tb_digit_loader;

  logic       clock = 1'b0;
  logic       clr;
  logic [9:0] keypad;
  logic       enter;
  logic       cancel;
  logic [3:0] digit;
  logic       loadn;
  logic       busy;
  logic [1:0] count;
  logic [3:0] d2, d1, d0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  digit_loader #(.DEBOUNCE(4)) dut (
    .clock(clock), .clr(clr), .keypad(keypad), .enter(enter), .cancel(cancel),
    .digit(digit), .loadn(loadn), .busy(busy), .count(count),
    .d2(d2), .d1(d1), .d0(d0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every loadn-low cycle must match the next digit expected by the scoreboard.
  always @(negedge clock) begin
    if (clr === 1'b0 && loadn === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", {28'd0, digit}, 32'hFFFF_FFFF);
      end else begin
        check("load_digit", {28'd0, digit}, {28'd0, exp_q.pop_front()});
        check("busy_during_load", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic press(input int k, input int hold);
    keypad    = '0;
    keypad[k] = 1'b1;
    repeat (hold) @(negedge clock);
    keypad = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic check_buf(input string tag, input logic [3:0] e2, input logic [3:0] e1,
                           input logic [3:0] e0, input logic [1:0] ec);
    check({tag, "_d2"}, {28'd0, d2}, {28'd0, e2});
    check({tag, "_d1"}, {28'd0, d1}, {28'd0, e1});
    check({tag, "_d0"}, {28'd0, d0}, {28'd0, e0});
    check({tag, "_count"}, {30'd0, count}, {30'd0, ec});
  endtask

  task automatic transfer(input string tag, input int exp_low, input int exp_busy);
    int low = 0;
    int bsy = 0;
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (loadn === 1'b0) low++;
      if (busy === 1'b1) bsy++;
    end
    check({tag, "_low_cycles"}, low, exp_low);
    check({tag, "_busy_cycles"}, bsy, exp_busy);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int guard;
    clr = 1'b1; keypad = '0; enter = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_loadn", {31'd0, loadn}, 32'd1);
    check("rst_digit", {28'd0, digit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_buf("rst", 4'd0, 4'd0, 4'd0, 2'd0);
    clr = 1'b0;
    repeat (2) @(negedge clock);

    // 1,9,9 then a full transfer.
    press(1, 6); press(9, 6); press(9, 6);
    check_buf("k199", 4'd1, 4'd9, 4'd9, 2'd3);
    exp_q.push_back(4'd1); exp_q.push_back(4'd9); exp_q.push_back(4'd9);
    transfer("xfer199", 3, 4);
    check_buf("after199", 4'd0, 4'd0, 4'd0, 2'd0);

    // Single digit pads with leading zeros.
    press(5, 6);
    check_buf("k5", 4'd0, 4'd0, 4'd5, 2'd1);
    exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd5);
    transfer("xfer5", 3, 4);

    // Fourth digit shifts the oldest out.
    press(1, 6); press(2, 6); press(3, 6); press(4, 6);
    check_buf("k1234", 4'd2, 4'd3, 4'd4, 2'd3);
    cancel = 1'b1; @(negedge clock); cancel = 1'b0;
    repeat (3) @(negedge clock);
    check_buf("cancel", 4'd0, 4'd0, 4'd0, 2'd0);

    // Debounce boundary, long hold, and a two-key chord.
    press(7, 3);
    check_buf("short7", 4'd0, 4'd0, 4'd0, 2'd0);
    press(7, 20);
    check_buf("long7", 4'd0, 4'd0, 4'd7, 2'd1);
    keypad = 10'b0000011000;
    repeat (12) @(negedge clock);
    keypad = '0;
    repeat (2) @(negedge clock);
    check_buf("chord34", 4'd0, 4'd0, 4'd7, 2'd1);

    // Cancel beats enter; enter with an empty buffer does nothing.
    press(4, 6); press(2, 6);
    check_buf("k742", 4'd7, 4'd4, 4'd2, 2'd3);
    cancel = 1'b1;
    transfer("cancel_enter", 0, 0);
    cancel = 1'b0;
    check_buf("after_ce", 4'd0, 4'd0, 4'd0, 2'd0);
    transfer("empty_enter", 0, 0);

    // Reset during LOAD1 aborts the transfer and drops key 8.
    press(1, 6); press(2, 6); press(3, 6);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    guard = 0;
    while (loadn !== 1'b0 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("load0_reached", {31'd0, loadn}, 32'd0);
    @(posedge clock);
    #1 keypad = '0; keypad[8] = 1'b1;
    #2 clr = 1'b1;
    #1;
    check("abort_loadn", {31'd0, loadn}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_digit", {28'd0, digit}, 32'd0);
    check_buf("abort", 4'd0, 4'd0, 4'd0, 2'd0);
    check("abort_queue", exp_q.size(), 2);
    exp_q.delete();
    @(negedge clock);
    keypad = '0;
    repeat (3) @(negedge clock);
    clr = 1'b0;
    repeat (10) @(negedge clock);
    check_buf("post_abort", 4'd0, 4'd0, 4'd0, 2'd0);
    transfer("post_abort_enter", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_loader.md
DIGIT_LOADER -- requirements
Module: digit_loader

Interface
REQ-001 The module SHALL have parameter DEBOUNCE, default 4, the number of consecutive identical valid keypad samples required to accept a key (legal range 1..15).
REQ-002 The module SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port keypad, input, 10 bits: raw key lines, where bit k high means digit key k is held.
REQ-005 The module SHALL have port enter, input, 1 bit: raw start key, high while held.
REQ-006 The module SHALL have port cancel, input, 1 bit: raw cancel key, high while held.
REQ-007 The module SHALL have port digit, output, 4 bits: BCD digit presented to the timer digit input.
REQ-008 The module SHALL have port loadn, output, 1 bit: active-low load strobe to the timer; digit is valid while loadn=0.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a transfer to the timer is in progress.
REQ-010 The module SHALL have port count, output, 2 bits: number of digits currently buffered (0..3).
REQ-011 The module SHALL have ports d2, d1, d0, outputs, 4 bits each: buffered digits for the display, where d2 is the oldest (minutes) and d0 is the newest (seconds ones).

Function
REQ-012 Valid key: a sample is valid only when exactly one keypad bit is high; its code is the index of that bit (0..9). Zero bits or two or more bits high is invalid and resets the stability counter.
REQ-013 Debounce: a key SHALL be accepted once, on the cycle in which the same valid code has been sampled for DEBOUNCE consecutive cycles. After acceptance, no further acceptance until keypad==0 has been sampled for at least 1 cycle (re-arm).
REQ-014 Acceptance in IDLE SHALL shift the buffer: d2<=d1, d1<=d0, d0<=code, count<=min(count+1,3). A 4th or later digit discards the old d2 (shift-out).
REQ-015 Enter and cancel SHALL be edge-detected: the action fires on a 0->1 transition of the registered input. No debounce counter is applied to these keys.
REQ-016 Cancel rising edge in IDLE SHALL clear d2, d1 and d0 to 0 and count to 0. Cancel in LOAD is ignored.
REQ-017 FSM states: IDLE, LOAD0, LOAD1, LOAD2, DONE.
- IDLE->LOAD0 on an enter rising edge with count>0.
- An enter rising edge with count=0 is ignored.
- LOADn advances unconditionally each cycle; LOAD2->DONE; DONE->IDLE.
REQ-018 Transfer outputs:
- LOAD0: loadn=0, digit=d2.
- LOAD1: loadn=0, digit=d1.
- LOAD2: loadn=0, digit=d0.
- DONE: loadn=1, digit=0, and the buffer and count are cleared.
- Exactly 3 consecutive loadn-low cycles occur per transfer.
REQ-019 Latency: loadn SHALL fall on the first rising edge after the cycle in which the registered enter edge is detected.
REQ-020 busy=1 in LOAD0..LOAD2 and DONE; busy=0 in IDLE.
REQ-021 Outputs digit, loadn and busy SHALL be registered and glitch-free.
REQ-022 Keys accepted or pressed during LOAD0..DONE SHALL be discarded without affecting the buffer. The debounce/re-arm logic keeps running, so a key held across DONE is not re-accepted.
REQ-023 Simultaneous events in the same cycle in IDLE: cancel takes priority over enter, and enter takes priority over digit acceptance. A digit accepted in the same cycle as an enter edge is dropped.
REQ-024 Buffers with count<3 SHALL still send 3 digits. Unfilled leading positions are 0, so "5" loads 0,0,5.

Reset
REQ-025 While clr=1, regardless of clock, the following SHALL hold:
- state=IDLE, loadn=1, digit=0, busy=0, count=0, d2=d1=d0=0.
- Debounce counter and edge registers are cleared.
REQ-026 Assertion of clr mid-transfer SHALL abort immediately with loadn=1. The next enter after release starts a fresh transfer only if new digits are entered.

Verification
REQ-027 Press keys 1, 9, 9 (each held 6 cycles, released 2 cycles), then pulse enter -> d2,d1,d0=1,9,9, count=3; then loadn low 3 cycles with digit 1,9,9; busy for 4 cycles; afterwards count=0.
REQ-028 Press 5 only, then enter -> the transfer carries digit 0,0,5.
REQ-029 Press 1,2,3,4 -> d2,d1,d0=2,3,4 and count=3.
REQ-030 Hold key 7 for 3 cycles (DEBOUNCE=4) -> not accepted. Hold it 20 cycles -> accepted once. Keys 3 and 4 held together -> never accepted.
REQ-031 Press 4,2, then cancel and enter in the same cycle -> buffer cleared and no loadn pulse. Enter with count=0 -> no loadn pulse.
REQ-032 Assert clr during LOAD1 -> loadn=1 and busy=0 immediately, all outputs at reset values; key 8 pressed during LOAD1 is never buffered.
